// File: rtl/lfsr_cam_datapath.sv
// Purpose : LFSR-addressed associative store; writes land at LFSR-sequenced
//           addresses, a latched key is searched by walking the same sequence.
// Latency : a write is searchable on the next edge; a hit at sequence index k
//           raises Compare_Found after the (k+1)-th enabled step edge past the key load.
// Backpressure: none; strobes are taken as given. Compare_Found is a sticky level
//           that holds until the next Temp_Trigger or Reset.
// Ports   : Clock, Reset (sync, active-high); strobes WR, RD, Temp_Trigger,
//           LFSR_Enable, LFSR_Reset, Data_Compare_Enable; Data_In (write data / key);
//           outputs Compare_Found, Hit, Match_Address, Full.
// Option  : define LFSR_CAM_SEARCH_TIMEOUT_EN to end a search after depth misses
//           with Hit=0; without it the search LFSR cycles until a hit.
module lfsr_cam_datapath #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0] TAPS       = 4'b1001,
  parameter logic [ADDR_WIDTH-1:0] SEED       = 4'b0001
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WR,
  input  logic                  RD,
  input  logic                  Temp_Trigger,
  input  logic                  LFSR_Enable,
  input  logic                  LFSR_Reset,
  input  logic                  Data_Compare_Enable,
  input  logic [DATA_WIDTH-1:0] Data_In,
  output logic                  Compare_Found,
  output logic                  Hit,
  output logic [ADDR_WIDTH-1:0] Match_Address,
  output logic                  Full
);

  localparam int DEPTH = (1 << ADDR_WIDTH) - 1;  // address 0 is never produced
  localparam int NENT  = 1 << ADDR_WIDTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic [ADDR_WIDTH-1:0] lfsr_next(input logic [ADDR_WIDTH-1:0] l);
    return {l[ADDR_WIDTH-2:0], ^(l & TAPS)};
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [NENT];
  logic [DATA_WIDTH-1:0] mem_d [NENT];
  logic [NENT-1:0]       valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [ADDR_WIDTH-1:0] search_addr_q, search_addr_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  found_q, found_d;
  logic                  hit_q, hit_d;
  logic [ADDR_WIDTH-1:0] match_addr_q, match_addr_d;
`ifdef LFSR_CAM_SEARCH_TIMEOUT_EN
  logic [ADDR_WIDTH-1:0] step_q, step_d;
`endif

  logic step_en;
  logic is_match;

  always_comb begin
    mem_d         = mem_q;
    valid_d       = valid_q;
    write_addr_d  = write_addr_q;
    search_addr_d = search_addr_q;
    key_d         = key_q;
    count_d       = count_q;
    found_d       = found_q;
    hit_d         = hit_q;
    match_addr_d  = match_addr_q;
`ifdef LFSR_CAM_SEARCH_TIMEOUT_EN
    step_d        = step_q;
`endif

    // Once terminated, the search stays frozen until a new key is loaded.
    step_en  = RD & LFSR_Enable & Data_Compare_Enable & ~found_q;
    // Reads the pre-write array, so a same-edge write is not seen by this compare.
    is_match = valid_q[search_addr_q] && (mem_q[search_addr_q] == key_q);

    // Writing past full simply overwrites the oldest entry: the write LFSR
    // has wrapped back to it.
    if (WR) begin
      mem_d[write_addr_q]   = Data_In;
      valid_d[write_addr_q] = 1'b1;
      write_addr_d          = lfsr_next(write_addr_q);
      if (count_q != CNT_W'(DEPTH)) begin
        count_d = count_q + CNT_W'(1);
      end
    end

    if (Temp_Trigger) begin
      key_d         = Data_In;
      search_addr_d = SEED;
      found_d       = 1'b0;
      hit_d         = 1'b0;
      match_addr_d  = '0;
`ifdef LFSR_CAM_SEARCH_TIMEOUT_EN
      step_d        = '0;
`endif
    end else if (LFSR_Reset) begin
      search_addr_d = SEED;
`ifdef LFSR_CAM_SEARCH_TIMEOUT_EN
      step_d        = '0;
`endif
    end else if (step_en) begin
      if (is_match) begin
        found_d      = 1'b1;
        hit_d        = 1'b1;
        match_addr_d = search_addr_q;
      end else begin
        search_addr_d = lfsr_next(search_addr_q);
`ifdef LFSR_CAM_SEARCH_TIMEOUT_EN
        // Every address has been visited once: report a miss.
        if (step_q == ADDR_WIDTH'(DEPTH - 1)) begin
          found_d = 1'b1;
          hit_d   = 1'b0;
        end else begin
          step_d = step_q + ADDR_WIDTH'(1);
        end
`endif
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mem_q         <= '{default: '0};
      valid_q       <= '0;
      write_addr_q  <= SEED;
      search_addr_q <= SEED;
      key_q         <= '0;
      count_q       <= '0;
      found_q       <= 1'b0;
      hit_q         <= 1'b0;
      match_addr_q  <= '0;
`ifdef LFSR_CAM_SEARCH_TIMEOUT_EN
      step_q        <= '0;
`endif
    end else begin
      mem_q         <= mem_d;
      valid_q       <= valid_d;
      write_addr_q  <= write_addr_d;
      search_addr_q <= search_addr_d;
      key_q         <= key_d;
      count_q       <= count_d;
      found_q       <= found_d;
      hit_q         <= hit_d;
      match_addr_q  <= match_addr_d;
`ifdef LFSR_CAM_SEARCH_TIMEOUT_EN
      step_q        <= step_d;
`endif
    end
  end

  assign Compare_Found = found_q;
  assign Hit           = hit_q;
  assign Match_Address = match_addr_q;
  assign Full          = (count_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_lfsr_cam_datapath.sv
module tb_lfsr_cam_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr, rd, tt, lfsr_en, lfsr_rst, dce;
  logic [7:0] din;
  logic       found, hit, full;
  logic [3:0] maddr;

  always #5 clk = ~clk;

  lfsr_cam_datapath dut (
    .Clock               (clk),
    .Reset               (rst),
    .WR                  (wr),
    .RD                  (rd),
    .Temp_Trigger        (tt),
    .LFSR_Enable         (lfsr_en),
    .LFSR_Reset          (lfsr_rst),
    .Data_Compare_Enable (dce),
    .Data_In             (din),
    .Compare_Found       (found),
    .Hit                 (hit),
    .Match_Address       (maddr),
    .Full                (full)
  );

  typedef struct packed {
    logic       found;
    logic       hit;
    logic [3:0] addr;
    logic       full;
  } exp_t;

  // Control word: {reset, write, key load, compare step, search lfsr reload}
  localparam logic [4:0] C_RST = 5'b10000;
  localparam logic [4:0] C_WR  = 5'b01000;
  localparam logic [4:0] C_TT  = 5'b00100;
  localparam logic [4:0] C_SE  = 5'b00010;
  localparam logic [4:0] C_LR  = 5'b00001;
  localparam logic [4:0] C_NO  = 5'b00000;

`ifdef LFSR_CAM_SEARCH_TIMEOUT_EN
  localparam logic MF = 1'b1;  // a miss terminates the search
`else
  localparam logic MF = 1'b0;  // a miss keeps searching
`endif

  typedef struct {
    logic [4:0] ctl;
    logic [7:0] d;
    int         rep;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total    = 0;

  function automatic exp_t ex(input logic f, input logic h, input logic [3:0] a, input logic fu);
    exp_t r;
    r.found = f;
    r.hit   = h;
    r.addr  = a;
    r.full  = fu;
    return r;
  endfunction

  function automatic vec_t mk(input logic [4:0] c, input logic [7:0] d, input int rep, input exp_t e);
    vec_t v;
    v.ctl = c;
    v.d   = d;
    v.rep = rep;
    v.e   = e;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue what must be seen after the edge,
  // then pop and compare against the DUT outputs just after that edge.
  task automatic cyc(input logic [4:0] c, input logic [7:0] d, input exp_t e, input string tag);
    exp_t got, want;
    rst      = c[4];
    wr       = c[3];
    tt       = c[2];
    rd       = c[1];
    lfsr_en  = c[1];
    dce      = c[1];
    lfsr_rst = c[0];
    din      = d;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got  = ex(found, hit, maddr, full);
    total++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got found=%0b hit=%0b addr=%h full=%0b",
               tag, got.found, got.hit, got.addr, got.full);
    end else begin
      want = sb_q.pop_front();
      if (got === want) begin
        pass_cnt++;
      end else begin
        $display("FAIL %s: got found=%0b hit=%0b addr=%h full=%0b, want found=%0b hit=%0b addr=%h full=%0b",
                 tag, got.found, got.hit, got.addr, got.full,
                 want.found, want.hit, want.addr, want.full);
      end
    end
  endtask

  // Load a key, then step n times; all steps but the last expect 'idle',
  // the last expects 'last'.
  task automatic search(input logic [7:0] key, input int n, input logic fu,
                        input exp_t last, input string tag);
    cyc(C_TT, key, ex(1'b0, 1'b0, 4'h0, fu), {tag, "_load"});
    for (int s = 0; s < n - 1; s++) cyc(C_SE, 8'h00, ex(1'b0, 1'b0, 4'h0, fu), {tag, "_step"});
    cyc(C_SE, 8'h00, last, {tag, "_end"});
  endtask

  vec_t tbl[17];

  initial begin
    // Basic writes and a hit; LFSR sequence 0001,0011,0111,1111,...
    tbl[0]  = mk(C_RST,        8'h00, 1,  ex(1'b0, 1'b0, 4'h0, 1'b0));
    tbl[1]  = mk(C_WR,         8'hA5, 1,  ex(1'b0, 1'b0, 4'h0, 1'b0));
    tbl[2]  = mk(C_WR,         8'h3C, 1,  ex(1'b0, 1'b0, 4'h0, 1'b0));
    tbl[3]  = mk(C_WR,         8'h7E, 1,  ex(1'b0, 1'b0, 4'h0, 1'b0));
    tbl[4]  = mk(C_TT,         8'h3C, 1,  ex(1'b0, 1'b0, 4'h0, 1'b0));
    tbl[5]  = mk(C_SE,         8'h00, 1,  ex(1'b0, 1'b0, 4'h0, 1'b0));
    tbl[6]  = mk(C_SE,         8'h00, 1,  ex(1'b1, 1'b1, 4'h3, 1'b0));
    tbl[7]  = mk(C_SE,         8'h00, 2,  ex(1'b1, 1'b1, 4'h3, 1'b0));
    tbl[8]  = mk(C_LR,         8'h00, 1,  ex(1'b1, 1'b1, 4'h3, 1'b0));
    // Absent key: miss after exactly 15 steps when the timeout is built in.
    tbl[9]  = mk(C_TT,         8'h99, 1,  ex(1'b0, 1'b0, 4'h0, 1'b0));
    tbl[10] = mk(C_SE,         8'h00, 14, ex(1'b0, 1'b0, 4'h0, 1'b0));
    tbl[11] = mk(C_SE,         8'h00, 1,  ex(MF,   1'b0, 4'h0, 1'b0));
    tbl[12] = mk(C_SE,         8'h00, 85, ex(MF,   1'b0, 4'h0, 1'b0));
    // Write during step 2 lands at 1111 and is found by step 3.
    tbl[13] = mk(C_TT,         8'h42, 1,  ex(1'b0, 1'b0, 4'h0, 1'b0));
    tbl[14] = mk(C_SE,         8'h00, 2,  ex(1'b0, 1'b0, 4'h0, 1'b0));
    tbl[15] = mk(C_SE | C_WR,  8'h42, 1,  ex(1'b0, 1'b0, 4'h0, 1'b0));
    tbl[16] = mk(C_SE,         8'h00, 1,  ex(1'b1, 1'b1, 4'hF, 1'b0));

    for (int i = 0; i < 17; i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        cyc(tbl[i].ctl, tbl[i].d, tbl[i].e, $sformatf("vec%0d", i));
      end
    end

    // Fill all 15 entries with 0x10..0x1E; Full rises on the 15th write.
    cyc(C_RST, 8'h00, ex(1'b0, 1'b0, 4'h0, 1'b0), "fill_rst");
    for (int i = 0; i < 15; i++) begin
      cyc(C_WR, 8'h10 + 8'(i), ex(1'b0, 1'b0, 4'h0, (i == 14)), $sformatf("fill%0d", i));
    end
    cyc(C_WR, 8'hFF, ex(1'b0, 1'b0, 4'h0, 1'b1), "wrap_wr");
    search(8'hFF, 1,  1'b1, ex(1'b1, 1'b1, 4'h1, 1'b1), "srch_ff");
    search(8'h11, 2,  1'b1, ex(1'b1, 1'b1, 4'h3, 1'b1), "srch_11");
    search(8'h1E, 15, 1'b1, ex(1'b1, 1'b1, 4'h8, 1'b1), "srch_1e");
    search(8'h10, 15, 1'b1, ex(MF,   1'b0, 4'h0, 1'b1), "srch_10");

    // Reset at step 5 of a search for 0x16 (stored at index 6, 1010).
    cyc(C_TT, 8'h16, ex(1'b0, 1'b0, 4'h0, 1'b1), "mid_load");
    for (int s = 0; s < 5; s++) cyc(C_SE, 8'h00, ex(1'b0, 1'b0, 4'h0, 1'b1), "mid_step");
    cyc(C_RST | C_SE | C_WR, 8'h16, ex(1'b0, 1'b0, 4'h0, 1'b0), "mid_rst");
    search(8'h16, 15, 1'b0, ex(MF, 1'b0, 4'h0, 1'b0), "post_rst");

    // Duplicate keys: first in sequence order wins.
    cyc(C_RST, 8'h00, ex(1'b0, 1'b0, 4'h0, 1'b0), "dup_rst");
    cyc(C_WR,  8'h55, ex(1'b0, 1'b0, 4'h0, 1'b0), "dup_wr0");
    cyc(C_WR,  8'h55, ex(1'b0, 1'b0, 4'h0, 1'b0), "dup_wr1");
    search(8'h55, 1, 1'b0, ex(1'b1, 1'b1, 4'h1, 1'b0), "dup");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks done", pass_cnt, total);
    $fatal(1);
  end

endmodule
